car_warning_annunciator: RTL

- Dashboard-side consumer of the blue/red warning-lamp requests produced by the car sensor logic.
- Debounces both lamp requests and the driver acknowledge button.
- Runs one latch/acknowledge state machine per lamp. Drives the physical LEDs: blinking while a fault is unacknowledged, solid once acknowledged.
- Drives a chime for unacknowledged red faults and counts fault events.

---
 rtl/car_warning_annunciator_pkg.sv | 25 ++
 rtl/car_warning_annunciator_debounce.sv | 52 +++++
 rtl/car_warning_annunciator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/car_warning_annunciator_pkg.sv
// Shared definitions for the car warning annunciator.
//   - Lamp FSM state encodings (2-bit, legacy-compatible constants)
//   - Fault counter saturation limit
//   - Saturating add helper for the fault counter
package car_warning_annunciator_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ALERT   = 2'd1;
  localparam logic [1:0] ST_LATCHED = 2'd2;
  localparam logic [1:0] ST_ACKED   = 2'd3;

  localparam logic [7:0] FAULT_COUNT_MAX = 8'd255;

  // Adds 0..2 new fault events and clamps at FAULT_COUNT_MAX.
  // The sum is one bit wider so that 254 + 2 clamps to 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    if (sum > {1'b0, FAULT_COUNT_MAX}) begin
      return FAULT_COUNT_MAX;
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/car_warning_annunciator_debounce.sv
// Input conditioner: 2-flop synchronizer followed by a stability-counter debouncer.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   raw  - asynchronous raw input
//   db   - debounced output; follows the synchronized input once it has differed
//          from db for DEBOUNCE_CYCLES consecutive cycles
// A stable change on raw shows up on db exactly DEBOUNCE_CYCLES+2 cycles later.
module car_warning_annunciator_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != db_reg) begin
        // The cycle that completes the run adopts the new value and re-arms.
        if (cnt_reg == CNT_LAST) begin
          db_reg  <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        // Any sample agreeing with db is a glitch end: the run starts over.
        cnt_reg <= '0;
      end
    end
  end

  assign db = db_reg;

endmodule

// File: rtl/car_warning_annunciator.sv
// Dashboard warning annunciator.
// Ports:
//   clk          - system clock (100 MHz)
//   rst          - synchronous active-high reset
//   blue_req     - raw blue-lamp request (coolant/oil level fault)
//   red_req      - raw red-lamp request (temperature fault)
//   ack_btn      - raw driver acknowledge button, active-high
//   led0         - blue lamp: blinks while unacknowledged, solid once acknowledged
//   led15        - red lamp, same behaviour
//   chime        - high while the red lamp is in ALERT
//   fault_count  - saturating count of IDLE->ALERT transitions over both lamps
module car_warning_annunciator
  import car_warning_annunciator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_HALF      = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blue_req,
  input  logic       red_req,
  input  logic       ack_btn,
  output logic       led0,
  output logic       led15,
  output logic       chime,
  output logic [7:0] fault_count
);

  localparam int unsigned BW = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Bit 0 = blue, bit 1 = red, bit 2 = acknowledge button.
  logic [2:0] raw_vec;
  logic [2:0] db_vec;

  assign raw_vec = {ack_btn, red_req, blue_req};

  for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
    car_warning_annunciator_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk(clk),
      .rst(rst),
      .raw(raw_vec[gi]),
      .db (db_vec[gi])
    );
  end

  // Rising-edge detect on the debounced button: a held button yields one pulse.
  logic ack_prev_reg;
  logic ack_pulse;

  assign ack_pulse = db_vec[2] & ~ack_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_prev_reg <= 1'b0;
    end else begin
      ack_prev_reg <= db_vec[2];
    end
  end

  // Free-running blink generator; phase starts lit so a new alert is
  // immediately visible after reset.
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  // One latch/acknowledge FSM per lamp (0 = blue, 1 = red). The shared
  // ack_pulse acknowledges both lamps in the same cycle.
  logic [1:0] led_vec;
  logic [1:0] alert_vec;
  logic [1:0] entry_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lamp
    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       led_reg;
    logic       req;

    assign req = db_vec[gi];

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        ST_IDLE: begin
          if (req) state_next = ST_ALERT;
        end
        ST_ALERT: begin
          // Acknowledge wins over a simultaneous request change.
          if (ack_pulse)  state_next = req ? ST_ACKED : ST_IDLE;
          else if (!req)  state_next = ST_LATCHED;
        end
        ST_LATCHED: begin
          if (ack_pulse)  state_next = ST_IDLE;
          else if (req)   state_next = ST_ALERT;
        end
        ST_ACKED: begin
          if (!req) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= ST_IDLE;
        led_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        case (state_reg)
          ST_IDLE:  led_reg <= 1'b0;
          ST_ACKED: led_reg <= 1'b1;
          default:  led_reg <= blink_phase_reg;
        endcase
      end
    end

    assign led_vec[gi]   = led_reg;
    assign alert_vec[gi] = (state_reg == ST_ALERT);
    // Only a fresh fault counts; LATCHED->ALERT re-entry does not.
    assign entry_vec[gi] = (state_reg == ST_IDLE) && req;
  end

  logic       chime_reg;
  logic [7:0] fault_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chime_reg       <= 1'b0;
      fault_count_reg <= 8'd0;
    end else begin
      chime_reg       <= alert_vec[1];
      fault_count_reg <= sat_add(fault_count_reg,
                                 {1'b0, entry_vec[0]} + {1'b0, entry_vec[1]});
    end
  end

  assign led0        = led_vec[0];
  assign led15       = led_vec[1];
  assign chime       = chime_reg;
  assign fault_count = fault_count_reg;

endmodule
